// File: rtl/regfile_wb_sink_if.sv
// Writeback/read/reservation bundle between the pipeline and the register file.
// The master modport is the pipeline side (stage 5 writeback plus decode). The
// slave modport is the register file.
interface regfile_wb_sink_if #(
  parameter int unsigned DATA_W = 32
);
  logic              do_wb_i;
  logic [3:0]        wb_reg_i;
  logic [DATA_W-1:0] wb_val_i;
  logic [3:0]        rd_a_reg_i;
  logic [DATA_W-1:0] rd_a_val_o;
  logic [3:0]        rd_b_reg_i;
  logic [DATA_W-1:0] rd_b_val_o;
  logic              reserve_i;
  logic [3:0]        reserve_reg_i;
  logic              hazard_o;
  logic              pend_err_o;

  modport master (
    output do_wb_i, wb_reg_i, wb_val_i, rd_a_reg_i, rd_b_reg_i, reserve_i, reserve_reg_i,
    input  rd_a_val_o, rd_b_val_o, hazard_o, pend_err_o
  );

  modport slave (
    input  do_wb_i, wb_reg_i, wb_val_i, rd_a_reg_i, rd_b_reg_i, reserve_i, reserve_reg_i,
    output rd_a_val_o, rd_b_val_o, hazard_o, pend_err_o
  );
endinterface

// File: rtl/regfile_wb_sink.sv
// Architectural register file at the end of the writeback path. It has two
// combinational read ports and a per-register pending-write scoreboard, which
// decode uses to stall on RAW hazards.
// Optional feature macro: REGFILE_BYPASS_EN. When it is defined, a writeback
// is visible on the read ports in the same cycle, and a register whose last
// outstanding write lands this cycle no longer raises a hazard.
module regfile_wb_sink #(
  parameter int unsigned NREGS  = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PEND_W = 2
) (
  input logic              clk_i,
  input logic              rst_n_i,
  regfile_wb_sink_if.slave bus
);

  localparam logic [PEND_W-1:0] PendMax = '1;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [PEND_W-1:0] pend_q [NREGS];
  logic [PEND_W-1:0] pend_d [NREGS];
  logic              pend_err_q;
  logic              pend_err_d;
  logic              res_hit [NREGS];
  logic              wb_hit  [NREGS];

  // Decode which register, if any, is being reserved or written this cycle.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      res_hit[r] = bus.reserve_i && (int'(bus.reserve_reg_i) == r);
      wb_hit[r]  = bus.do_wb_i && (int'(bus.wb_reg_i) == r);
    end
  end

  // Scoreboard next state. The counter saturates at both ends and flags the
  // misuse. A reserve and a writeback to the same register cancel out.
  always_comb begin
    pend_err_d = pend_err_q;
    for (int r = 0; r < NREGS; r++) begin
      pend_d[r] = pend_q[r];
      if (res_hit[r] && !wb_hit[r]) begin
        if (pend_q[r] == PendMax) begin
          pend_err_d = 1'b1;
        end else begin
          pend_d[r] = pend_q[r] + PEND_W'(1);
        end
      end else if (wb_hit[r] && !res_hit[r]) begin
        if (pend_q[r] == '0) begin
          pend_err_d = 1'b1;
        end else begin
          pend_d[r] = pend_q[r] - PEND_W'(1);
        end
      end
    end
  end

  // Register array, scoreboard counters and sticky error flag.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
        pend_q[r] <= '0;
      end
      pend_err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        if (wb_hit[r]) begin
          regs_q[r] <= bus.wb_val_i;
        end
        pend_q[r] <= pend_d[r];
      end
      pend_err_q <= pend_err_d;
    end
  end

  logic [PEND_W-1:0] pend_a;
  logic [PEND_W-1:0] pend_b;
  logic              wb_a;
  logic              wb_b;

  assign pend_a = pend_q[bus.rd_a_reg_i];
  assign pend_b = pend_q[bus.rd_b_reg_i];
  assign wb_a   = bus.do_wb_i && (bus.wb_reg_i == bus.rd_a_reg_i);
  assign wb_b   = bus.do_wb_i && (bus.wb_reg_i == bus.rd_b_reg_i);

`ifdef REGFILE_BYPASS_EN
  // Write-through read ports. The hazard drops in the cycle that the last
  // outstanding write arrives.
  always_comb begin
    rd_a_val_o_mux: begin end
    bus.rd_a_val_o = wb_a ? bus.wb_val_i : regs_q[bus.rd_a_reg_i];
    bus.rd_b_val_o = wb_b ? bus.wb_val_i : regs_q[bus.rd_b_reg_i];
    bus.hazard_o   = ((pend_a != '0) && !(wb_a && (pend_a == PEND_W'(1)))) ||
                     ((pend_b != '0) && !(wb_b && (pend_b == PEND_W'(1))));
  end
`else
  // Plain array reads. During the writeback cycle the old value is still
  // visible, so the hazard stays up until the write has landed.
  always_comb begin
    bus.rd_a_val_o = regs_q[bus.rd_a_reg_i];
    bus.rd_b_val_o = regs_q[bus.rd_b_reg_i];
    bus.hazard_o   = (pend_a != '0) || (pend_b != '0);
    if (wb_a && wb_b) begin
      // Writebacks have no effect on the read path without bypass.
    end
  end
`endif

  assign bus.pend_err_o = pend_err_q;

endmodule

// File: tb/tb_regfile_wb_sink.sv
// Self-checking bench for regfile_wb_sink. The driver issues one transaction
// per cycle and pushes the expected outputs, which it takes from a
// behavioural model, into a queue. A monitor pops the queue and compares on
// each falling edge.
module tb_regfile_wb_sink;

`ifdef REGFILE_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif
  localparam int PMax = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_sink_if #(.DATA_W(32)) bus ();

  regfile_wb_sink #(
    .NREGS (16),
    .DATA_W(32),
    .PEND_W(2)
  ) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        haz;
    logic        err;
    string       tag;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mregs[16];
  int          mpend[16];
  bit          merr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 16; r++) begin
      mregs[r] = '0;
      mpend[r] = 0;
    end
    merr = 1'b0;
  endtask

  // A register is stalled if a write is outstanding, unless bypass allows the
  // final outstanding write to be consumed in the cycle that it arrives.
  function automatic bit stalled(input int sel, input bit wb, input int wr);
    return (mpend[sel] != 0) && !(Byp && wb && (wr == sel) && (mpend[sel] == 1));
  endfunction

  task automatic cyc(input string tag, input bit wb, input int wr, input logic [31:0] wv,
                     input int ra, input int rb, input bit res, input int rr);
    exp_t e;
    int   delta[16];
    @(posedge clk);
    #1;
    bus.do_wb_i       = wb;
    bus.wb_reg_i      = 4'(wr);
    bus.wb_val_i      = wv;
    bus.rd_a_reg_i    = 4'(ra);
    bus.rd_b_reg_i    = 4'(rb);
    bus.reserve_i     = res;
    bus.reserve_reg_i = 4'(rr);
    e.a   = (Byp && wb && wr == ra) ? wv : mregs[ra];
    e.b   = (Byp && wb && wr == rb) ? wv : mregs[rb];
    e.haz = stalled(ra, wb, wr) || stalled(rb, wb, wr);
    e.err = merr;
    e.tag = tag;
    sbq.push_back(e);
    // Apply the effect of the coming clock edge to the model.
    for (int r = 0; r < 16; r++) delta[r] = 0;
    if (res) delta[rr] += 1;
    if (wb) begin
      delta[wr] -= 1;
      mregs[wr] = wv;
    end
    for (int r = 0; r < 16; r++) begin
      int n;
      n = mpend[r] + delta[r];
      if (n < 0) begin
        merr = 1'b1;
        n = 0;
      end
      if (n > PMax) begin
        merr = 1'b1;
        n = PMax;
      end
      mpend[r] = n;
    end
  endtask

  // Monitor: compare the DUT outputs with the queued expectation on each falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk({e.tag, "/rd_a"}, bus.rd_a_val_o, e.a);
        chk({e.tag, "/rd_b"}, bus.rd_b_val_o, e.b);
        chk({e.tag, "/hazard"}, 32'(bus.hazard_o), 32'(e.haz));
        chk({e.tag, "/pend_err"}, 32'(bus.pend_err_o), 32'(e.err));
      end
    end
  end

  initial begin
    int wr;
    int rr;
    int cand[$];
    bus.do_wb_i       = 1'b0;
    bus.wb_reg_i      = '0;
    bus.wb_val_i      = '0;
    bus.rd_a_reg_i    = '0;
    bus.rd_b_reg_i    = '0;
    bus.reserve_i     = 1'b0;
    bus.reserve_reg_i = '0;
    model_reset();
    #1;
    chk("por/rd_a", bus.rd_a_val_o, 32'h0);
    chk("por/hazard", 32'(bus.hazard_o), 32'h0);
    chk("por/pend_err", 32'(bus.pend_err_o), 32'h0);
    #12 rst_n = 1'b1;

    // Write then read on both ports.
    cyc("wr5", 1, 5, 32'hDEADBEEF, 0, 1, 0, 0);
    cyc("rd5", 0, 0, 0, 5, 5, 0, 0);
    // RAW stall on r7.
    cyc("raw_res", 0, 0, 0, 0, 7, 1, 7);
    cyc("raw_c1", 0, 0, 0, 0, 7, 0, 0);
    cyc("raw_c2", 0, 0, 0, 0, 7, 0, 0);
    cyc("raw_wb", 1, 7, 32'h55, 0, 7, 0, 0);
    cyc("raw_c4", 0, 0, 0, 0, 7, 0, 0);
    // Two writes in flight to r2.
    cyc("mf_r1", 0, 0, 0, 2, 0, 1, 2);
    cyc("mf_r2", 0, 0, 0, 2, 0, 1, 2);
    cyc("mf_wb1", 1, 2, 32'h1, 2, 0, 0, 0);
    cyc("mf_wb2", 1, 2, 32'h2, 2, 0, 0, 0);
    cyc("mf_c1", 0, 0, 0, 2, 0, 0, 0);
    cyc("mf_c2", 0, 0, 0, 2, 2, 0, 0);
    // Reserve and writeback in the same cycle.
    cyc("sim_r4", 0, 0, 0, 4, 0, 1, 4);
    cyc("sim_rw4", 1, 4, 32'h44, 4, 0, 1, 4);
    cyc("sim_c4", 0, 0, 0, 4, 0, 0, 0);
    cyc("sim_r9", 0, 0, 0, 0, 9, 1, 9);
    cyc("sim_r4w9", 1, 9, 32'h99, 4, 9, 1, 4);
    cyc("sim_c49", 0, 0, 0, 4, 9, 0, 0);
    // Error flag: writeback underflow, then reserve saturation.
    cyc("uf_wb1", 1, 1, 32'hAB, 1, 0, 0, 0);
    cyc("uf_c1", 0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc("sat_r6", 0, 0, 0, 0, 6, 1, 6);
    cyc("sat_c6", 0, 0, 0, 6, 6, 0, 0);
    // Asynchronous reset in the middle of the run, after r3 has been written.
    cyc("wr3", 1, 3, 32'h1234, 3, 3, 0, 0);
    cyc("rd3", 0, 0, 0, 3, 3, 0, 0);
    @(posedge clk);
    #1;
    bus.do_wb_i    = 1'b0;
    bus.reserve_i  = 1'b0;
    bus.rd_a_reg_i = 4'd3;
    bus.rd_b_reg_i = 4'd6;
    rst_n          = 1'b0;
    #1;
    chk("arst/rd_a", bus.rd_a_val_o, 32'h0);
    chk("arst/hazard", 32'(bus.hazard_o), 32'h0);
    chk("arst/pend_err", 32'(bus.pend_err_o), 32'h0);
    model_reset();
    #2 rst_n = 1'b1;

    // Random phase. Writebacks mostly target registers that have pending writes.
    for (int i = 0; i < 600; i++) begin
      cand.delete();
      for (int r = 0; r < 16; r++) if (mpend[r] != 0) cand.push_back(r);
      wr = (cand.size() > 0 && $urandom_range(0, 3) != 0) ?
           cand[$urandom_range(0, cand.size() - 1)] : int'($urandom_range(0, 15));
      rr = int'($urandom_range(0, 15));
      cyc("rand", $urandom_range(0, 1) == 1, wr, $urandom(),
          int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
          $urandom_range(0, 2) == 0, rr);
    end

    for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
    #1;
    if (sbq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain actual=%0d required=0 pending expectations", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_sink.md
Name: regfile_wb_sink

Overview:
- Architectural register file at the receiving end of the writeback path. It sits beside stage 2 (decode).
- Consumes the registered writeback triple (do_wb/wb_reg/wb_val) from stage 5.
- Provides two asynchronous read ports to decode.
- Keeps a per-register pending-write scoreboard so decode can stall on RAW hazards until the matching writeback arrives.

Parameters:
NREGS, 16, number of architectural registers (reg index width fixed at 4)
DATA_W, 32, register width in bits
PEND_W, 2, width of each per-register pending-write counter (max 2^PEND_W-1 in flight)

Ports:
clk_i  in  1  core clock
rst_n_i  in  1  asynchronous active-low reset
do_wb_i  in  1  writeback strobe from stage 5
wb_reg_i  in  4  writeback destination register
wb_val_i  in  32  writeback data
rd_a_reg_i  in  4  read port A register select
rd_a_val_o  out  32  read port A data
rd_b_reg_i  in  4  read port B register select
rd_b_val_o  out  32  read port B data
reserve_i  in  1  decode issued an instruction that will write reserve_reg_i
reserve_reg_i  in  4  register being reserved
hazard_o  out  1  port A or port B selects a register with an unresolved pending write
pend_err_o  out  1  sticky: scoreboard overflow or underflow detected

Behaviour:
- Reset: async assert on rst_n_i low. All registers <= 0, all pending counters <= 0, pend_err_o <= 0. Release is synchronous to clk_i; the first edge after release is an ordinary cycle.
- Write:
  - On posedge with do_wb_i=1, reg[wb_reg_i] <= wb_val_i.
  - All 16 registers are general purpose; r0 is not hardwired.
- Read:
  - Combinational: rd_x_val_o = reg[rd_x_reg_i], subject to bypass (see Optional Feature).
  - Zero-cycle latency from select to data.
- Scoreboard, per register r, pend[r] updated on each posedge:
  - reserve only (reserve_i=1, reserve_reg_i=r, no wb to r): pend[r]+1. If pend[r] is already max, counter holds and pend_err_o <= 1.
  - wb only (do_wb_i=1, wb_reg_i=r, no reserve to r): pend[r]-1. If pend[r]==0, the write still occurs, counter holds at 0 and pend_err_o <= 1.
  - reserve and wb to the same r in the same cycle: pend[r] unchanged, no error. This applies even at max or at 0.
  - reserve and wb to different registers: both updates apply independently.
- hazard_o (combinational): 1 iff either port's register is pending, i.e. pend[sel]!=0 and not resolved this cycle.
  - A port is resolved this cycle only when bypass is compiled in, do_wb_i=1, wb_reg_i==sel and pend[sel]==1.
  - Both ports are checked even when they select the same register.
- hazard_o does not look at reserve_i in the same cycle. A reservation affects the hazard from the next cycle on.
- pend_err_o is sticky until reset. It is a debug/assertion aid and has no effect on the datapath.

Optional Feature:
REGFILE_BYPASS_EN
- Defined:
  - If do_wb_i=1 and wb_reg_i==rd_x_reg_i, rd_x_val_o = wb_val_i in the same cycle (write-through).
  - hazard_o is suppressed for a register whose last outstanding write lands this cycle (pend==1).
- Undefined:
  - rd_x_val_o always returns the stored array value, so the old value is visible during the write cycle.
  - hazard_o stays asserted whenever pend[sel]!=0, including the writeback cycle. Decode stalls one extra cycle.

Test Plan:
1. Reset/read: assert rst_n_i low mid-run after writing r3=0x1234 -> r3 reads 0, hazard_o=0 and pend_err_o=0 immediately (async), with no clock edge required.
2. Write then read: wb r5=0xDEADBEEF, next cycle rd_a_reg_i=5 -> rd_a_val_o=0xDEADBEEF. With r5 selected on both ports, both outputs are equal.
3. RAW stall: reserve r7 at cycle 0; cycles 1-3 rd_b_reg_i=7 -> hazard_o=1. wb r7=0x55 at cycle 3 -> with BYPASS_EN, hazard_o=0 and rd_b_val_o=0x55 in cycle 3. Without it, hazard_o=1 in cycle 3, then 0 and value 0x55 in cycle 4.
4. Multiple in flight: reserve r2 twice, then a single wb r2=0x1 -> hazard_o remains 1. A second wb r2=0x2 -> hazard clears and r2=0x2.
5. Simultaneous reserve+wb on r4 with pend[r4]=1 -> pend stays 1, hazard_o=1 next cycle, pend_err_o=0. Reserve r4 and wb r9 in the same cycle -> both counters update.
6. Error flag: wb r1 with pend[r1]=0 -> r1 written, pend_err_o=1 and sticky. Separately, 4 reserves of r6 with PEND_W=2 -> counter saturates at 3 and pend_err_o=1.
